sign_cmp_sched: RTL and testbench
=================================

// Module: sign_cmp_sched
// PURPOSE
//  Shares one signed (sign-magnitude) >= comparator among N_REQ requesters.
//  Round-robin arbitration, registered operand capture, one compare stage, then a held response with backpressure.
//  Sits between client blocks and the sign-magnitude A>=B datapath; one comparison in flight at a time.
// PARAMETERS
//  N_REQ  4                 number of requesters (2..16)
//  DW     8                 operand width; MSB = sign, [DW-2:0] = magnitude
//  IDW    $clog2(N_REQ)     requester id width (derived, not overridden)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  req_valid  in   N_REQ      per-requester request valid
//  req_a      in   N_REQ*DW   operand A, requester i at [i*DW +: DW]
//  req_b      in   N_REQ*DW   operand B, same packing
//  req_ready  out  N_REQ      one-hot accept; a request is taken on valid&ready
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_id     out  IDW        requester index of the response
//  rsp_ageb   out  1          1 when A >= B (signed)
//  busy       out  1          high in any state except IDLE
//  cmp_count  out  16         completed responses, saturating
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_ageb=0, busy=0, cmp_count=0.
//  FSM IDLE -> CMP -> RESP -> IDLE.
//   IDLE: if any req_valid, grant the first valid index scanning rr_ptr, rr_ptr+1, .. (mod N_REQ).
//         req_ready = one-hot grant, driven combinationally, only in IDLE.
//         Latch opA/opB/id; go to CMP. No valid: stay.
//   CMP:  ageb_q <= cmp(opA,opB); go to RESP.
//   RESP: rsp_valid=1; rsp_id/rsp_ageb stable until rsp_valid&rsp_ready.
//         On handshake: rr_ptr <= (id+1) mod N_REQ; cmp_count++ (holds at 0xFFFF); go to IDLE.
//  Latency: accept edge -> rsp_valid high 2 cycles later. Max throughput 1 result per 3 cycles.
//  Compare rule: each operand is converted to two's complement: mag if sign=0, else -mag.
//   +0 and -0 (DW'h80..0) are equal. ageb = (tcA >= tcB) signed.
//   Range -(2^(DW-1)-1)..+(2^(DW-1)-1); no overflow possible.
//  A requester dropping req_valid before acceptance is legal; it is never granted.
//  Requests are not queued. req_valid during CMP/RESP is ignored; req_ready stays 0.
//  rsp_ready high outside RESP: no effect.
//  Reset mid-operation: in-flight request is dropped with no response; outputs take reset values on the next edge.
// CONFIGURATION
//  SIGN_CMP_SCHED_MAX_EN defined:
//   adds output rsp_max [DW-1:0]: the larger operand in original sign-magnitude form (A when ageb=1, else B).
//   Registered with rsp_ageb in CMP. Reset value 0.
//  Undefined: port absent, no max logic.
// STRUCTURE
//  Package sign_cmp_pkg:
//   DW default constant; typedef sm_t (logic [DW-1:0]); typedef tc_t (logic signed [DW-1:0]).
//   function sm2tc(sm_t) -> tc_t; state enum {IDLE,CMP,RESP}.
//  Sub-module sign_cmp_core: combinational a,b -> ageb using sm2tc.
//   Instanced once in CMP path; reusable by other blocks.
//  Arbiter is a rotate / priority-find / rotate-back in this module; no separate sub-module.
// TESTING
//  1 Reset: hold rst 3 cycles with all req_valid=1 -> all outputs 0, req_ready=0 throughout; first grant is id 0.
//  2 Single req0 A=8'h85(-5), B=8'h03(+3) -> req_ready[0] pulse, rsp_valid 2 cycles later, id=0, ageb=0.
//    Then A=8'h80, B=8'h00 -> ageb=1. Then A=8'h7F, B=8'hFF -> ageb=1.
//  3 All 4 req_valid held high, rsp_ready=1 -> grant/response id order 0,1,2,3,0,1; cmp_count increments per response.
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_valid,id,ageb stable; req_ready=0.
//    rsp_ready=1 -> IDLE next cycle; rr_ptr advanced.
//  5 Assert rst during CMP -> no response emitted; rsp_valid=0, busy=0 after edge.
//    Pending requesters re-arbitrated from id 0.
//  6 With SIGN_CMP_SCHED_MAX_EN: A=8'h82(-2), B=8'h81(-1) -> ageb=0, rsp_max=8'h81; without the macro, build has no rsp_max.

Source files
------------

// File: rtl/sign_cmp_pkg.sv
// sign_cmp_pkg: shared types and sign-magnitude helper for the shared comparator block.
// rev 1.0
`default_nettype none

package sign_cmp_pkg;

    localparam int DW_DEFAULT = 8;

    typedef logic [DW_DEFAULT-1:0]        sm_t;
    typedef logic signed [DW_DEFAULT-1:0] tc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // -0 maps to 0, so both zero encodings compare equal
    function automatic tc_t sm2tc(input sm_t v);
        tc_t mag;
        mag = $signed({1'b0, v[DW_DEFAULT-2:0]});
        return v[DW_DEFAULT-1] ? -mag : mag;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sign_cmp_core.sv
// sign_cmp_core: combinational signed (sign-magnitude) A >= B comparator.
// rev 1.0
`default_nettype none

module sign_cmp_core
    import sign_cmp_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          ageb_o
);

    generate
        if (DW == DW_DEFAULT) begin : g_pkg_conv
            assign ageb_o = (sm2tc(sm_t'(a_i)) >= sm2tc(sm_t'(b_i)));
        end else begin : g_generic_conv
            // Same mapping as sm2tc, widened to an overridden operand width
            logic signed [DW-1:0] ta;
            logic signed [DW-1:0] tb;
            assign ta = a_i[DW-1] ? -$signed({1'b0, a_i[DW-2:0]}) : $signed({1'b0, a_i[DW-2:0]});
            assign tb = b_i[DW-1] ? -$signed({1'b0, b_i[DW-2:0]}) : $signed({1'b0, b_i[DW-2:0]});
            assign ageb_o = (ta >= tb);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sign_cmp_sched.sv
// sign_cmp_sched: round-robin scheduler sharing one sign-magnitude A>=B comparator.
// Optional SIGN_CMP_SCHED_MAX_EN adds rsp_max (larger operand). rev 1.0
`default_nettype none

module sign_cmp_sched
    import sign_cmp_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_ageb,
    output logic                busy,
`ifdef SIGN_CMP_SCHED_MAX_EN
    output logic [DW-1:0]       rsp_max,
`endif
    output logic [15:0]         cmp_count
);

    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [IDW-1:0]   id_q;
    logic [DW-1:0]    op_a_q;
    logic [DW-1:0]    op_b_q;
    logic             ageb_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic [15:0]      cmp_count_q;
    logic [15:0]      cmp_count_d;

    logic [N_REQ-1:0] rot_valid;
    logic [N_REQ-1:0] grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             core_ageb;
    int               grant_off;

    function automatic int wrap(input int v);
        return (v >= N_REQ) ? v - N_REQ : v;
    endfunction

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot_valid = '0;
        grant_any = 1'b0;
        grant_off = 0;
        grant_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_valid[i] = req_valid[wrap(i + int'(rr_ptr_q))];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && rot_valid[i]) begin
                grant_any = 1'b1;
                grant_off = i;
            end
        end
        grant_idx = IDW'(wrap(grant_off + int'(rr_ptr_q)));
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;

    assign rr_ptr_d    = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    assign cmp_count_d = (cmp_count_q == 16'hFFFF) ? cmp_count_q : cmp_count_q + 16'd1;

    sign_cmp_core #(
        .DW     (DW)
    ) u_core (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .ageb_o (core_ageb)
    );

`ifdef SIGN_CMP_SCHED_MAX_EN
    logic [DW-1:0] max_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else if (state_q == CMP) begin
            max_q <= core_ageb ? op_a_q : op_b_q;
        end
    end
    assign rsp_max = max_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ageb_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmp_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        op_a_q  <= req_a[int'(grant_idx)*DW +: DW];
                        op_b_q  <= req_b[int'(grant_idx)*DW +: DW];
                        id_q    <= grant_idx;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    ageb_q      <= core_ageb;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        cmp_count_q <= cmp_count_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_ageb  = ageb_q;
    assign busy      = busy_q;
    assign cmp_count = cmp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sign_cmp_sched.sv
// tb_sign_cmp_sched: directed + randomized bench with an in-bench behavioural model.
// Define SIGN_CMP_SCHED_MAX_EN to also exercise rsp_max.
`default_nettype none

module tb_sign_cmp_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_ageb;
    logic            busy;
    logic [15:0]     cmp_count;
`ifdef SIGN_CMP_SCHED_MAX_EN
    logic [DW-1:0]   rsp_max;
`endif

    always #5 clk = ~clk;

    sign_cmp_sched #(.N_REQ(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ageb  (rsp_ageb),
        .busy      (busy),
`ifdef SIGN_CMP_SCHED_MAX_EN
        .rsp_max   (rsp_max),
`endif
        .cmp_count (cmp_count)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = waiting, 1 = comparing, 2 = result offered
    int          m_phase, m_ptr, m_id, m_pid, m_count;
    logic        m_ageb;
    logic [DW-1:0] m_a, m_b, m_max;
    int          grant_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tc(input logic [DW-1:0] v);
        int mag;
        mag = int'(v[DW-2:0]);
        return v[DW-1] ? -mag : mag;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_id = 0; m_pid = 0; m_count = 0;
        m_ageb = 1'b0; m_a = '0; m_b = '0; m_max = '0;
    endtask

    // Called at a negedge with inputs already driven; checks, steps the model, returns at next negedge
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rr;
        #1;
        g = pick();
        exp_rr = '0;
        if (!rst && m_phase == 0 && g >= 0) exp_rr[g] = 1'b1;
        chk("req_ready", req_ready, exp_rr);
        chk("busy", busy, m_phase != 0);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("cmp_count", cmp_count, m_count);
        if (m_phase != 1) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_ageb", rsp_ageb, m_ageb);
`ifdef SIGN_CMP_SCHED_MAX_EN
            chk("rsp_max", rsp_max, m_max);
`endif
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (g >= 0) begin
                m_a = req_a[g*DW +: DW];
                m_b = req_b[g*DW +: DW];
                m_pid = g;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_ageb = (tc(m_a) >= tc(m_b));
            m_max = m_ageb ? m_a : m_b;
            m_id = m_pid;
            m_phase = 2;
        end else if (rsp_ready) begin
            m_ptr = (m_id + 1) % N;
            if (m_count < 65535) m_count++;
            m_phase = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0; rsp_ready = 1'b1; rst = 1'b0;
        for (int i = 0; i < 10 && m_phase != 0; i++) cycle();
        checks++;
        if (m_phase != 0) begin
            errors++;
            $display("FAIL drain_timeout: phase %0d expected 0", m_phase);
        end
    endtask

    task automatic run_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic exp_ageb, input logic [DW-1:0] exp_max);
        drain();
        req_valid = 4'b0001; req_a[0 +: DW] = a; req_b[0 +: DW] = b; rsp_ready = 1'b0;
        grant_log.delete();
        cycle();
        chk({tag, "_accept"}, (grant_log.size() == 1) ? grant_log[0] : 99, 0);
        req_valid = '0;
        cycle();
        #1;
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_ageb"}, rsp_ageb, exp_ageb);
`ifdef SIGN_CMP_SCHED_MAX_EN
        chk({tag, "_max"}, rsp_max, exp_max);
`else
        if (exp_max != exp_max) $display("unreachable");
`endif
        rsp_ready = 1'b1;
        cycle();
    endtask

    initial begin
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        chk("model_tc_85", tc(8'h85), -5);
        chk("model_tc_80", tc(8'h80), 0);

        // Reset held with all requests valid
        repeat (3) cycle();
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_ready", req_ready, 0);
        rst = 1'b0;
        grant_log.delete();
        cycle();
        chk("t1_first_grant", (grant_log.size() > 0) ? grant_log[0] : 99, 0);

        run_one("t2a", 8'h85, 8'h03, 1'b0, 8'h03);
        run_one("t2b", 8'h80, 8'h00, 1'b1, 8'h80);
        run_one("t2c", 8'h7F, 8'hFF, 1'b1, 8'h7F);

        // Round-robin with everyone requesting
        rst = 1'b1; cycle(); rst = 1'b0;
        req_valid = '1; rsp_ready = 1'b1;
        grant_log.delete();
        repeat (18) cycle();
        #1;
        chk("t3_count", cmp_count, 6);
        for (int i = 0; i < 6; i++)
            chk("t3_order", (grant_log.size() > i) ? grant_log[i] : 99, i % 4);

        // Backpressure hold
        rsp_ready = 1'b0;
        grant_log.delete();
        cycle();
        cycle();
        repeat (5) begin
            cycle();
            #1;
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_id", rsp_id, 2);
        end
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("t4_next_grant", (grant_log.size() == 2) ? grant_log[1] : 99, 3);

        // Reset during compare
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("t5_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        grant_log.delete();
        cycle();
        chk("t5_regrant", (grant_log.size() > 0) ? grant_log[0] : 99, 0);

`ifdef SIGN_CMP_SCHED_MAX_EN
        run_one("t6", 8'h82, 8'h81, 1'b0, 8'h81);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0: req_a[i*DW +: DW] = 8'h80;
                    1: req_a[i*DW +: DW] = 8'h00;
                    default: req_a[i*DW +: DW] = DW'($urandom);
                endcase
                if ($urandom_range(0, 3) == 0)
                    req_b[i*DW +: DW] = req_a[i*DW +: DW] ^ 8'h80;
                else
                    req_b[i*DW +: DW] = DW'($urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
